// File: rtl/lsu_ctrl.sv
// Load/store controller in front of a doubleword RAM: lane extraction for loads, read-modify-write for stores.
// Optional: define LSU_BADADDR_EN to add resp_badaddr_o reporting the faulting address.
module lsu_ctrl #(
    parameter int unsigned DATA_LEN = 64,
    parameter int unsigned RAM_SIZE = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [DATA_LEN-1:0] req_addr_i,
    input  logic [DATA_LEN-1:0] req_wdata_i,
    input  logic [2:0]          req_memwid_i,
    output logic [RAM_SIZE-1:0] ram_addr_o,
    output logic [1:0]          ram_access_mode_o,
    output logic [2:0]          ram_memwid_o,
    output logic [DATA_LEN-1:0] ram_data_o,
    input  logic [DATA_LEN-1:0] ram_data_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [DATA_LEN-1:0] resp_rdata_o,
`ifdef LSU_BADADDR_EN
    output logic [DATA_LEN-1:0] resp_badaddr_o,
`endif
    output logic                resp_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_ERR,
        S_RESP
    } state_t;

    localparam logic [1:0] MODE_NONE  = 2'd0;
    localparam logic [1:0] MODE_READ  = 2'd1;
    localparam logic [1:0] MODE_WRITE = 2'd2;

    state_t              state_q;
    logic                we_q;
    logic [2:0]          memwid_q;
    logic [2:0]          off_q;
    logic [DATA_LEN-1:0] wdata_q;
`ifdef LSU_BADADDR_EN
    logic [DATA_LEN-1:0] addr_q;
`endif

    logic                req_fire;
    logic                req_bad;
    logic                bad_width;
    logic                misaligned;
    logic                out_of_range;
    logic [5:0]          lane_shamt;
    logic [DATA_LEN-1:0] lane_data;
    logic [DATA_LEN-1:0] lane_mask;
    logic [DATA_LEN-1:0] load_d;
    logic [DATA_LEN-1:0] merge_d;

    assign ram_memwid_o = 3'b011;
    assign req_fire     = req_valid_i && req_ready_o;

    // Unsigned widths are load-only; a store carrying one is rejected like 111.
    always_comb begin
        bad_width    = (req_memwid_i == 3'b111) || (req_we_i && req_memwid_i[2]);
        misaligned   = 1'b0;
        unique case (req_memwid_i[1:0])
            2'b01:   misaligned = req_addr_i[0];
            2'b10:   misaligned = |req_addr_i[1:0];
            2'b11:   misaligned = |req_addr_i[2:0];
            default: misaligned = 1'b0;
        endcase
        out_of_range = |req_addr_i[DATA_LEN-1:RAM_SIZE+3];
        req_bad      = bad_width || misaligned || out_of_range;
    end

    always_comb begin
        lane_shamt = {off_q, 3'b000};
        lane_data  = ram_data_i >> lane_shamt;
        lane_mask  = '0;
        unique case (memwid_q[1:0])
            2'b00:   lane_mask = {{(DATA_LEN-8){1'b0}},  8'hFF};
            2'b01:   lane_mask = {{(DATA_LEN-16){1'b0}}, 16'hFFFF};
            2'b10:   lane_mask = {{(DATA_LEN-32){1'b0}}, 32'hFFFF_FFFF};
            default: lane_mask = '1;
        endcase
        load_d = '0;
        unique case (memwid_q)
            3'b000:  load_d = {{(DATA_LEN-8){lane_data[7]}},   lane_data[7:0]};
            3'b001:  load_d = {{(DATA_LEN-16){lane_data[15]}}, lane_data[15:0]};
            3'b010:  load_d = {{(DATA_LEN-32){lane_data[31]}}, lane_data[31:0]};
            3'b011:  load_d = lane_data;
            3'b100:  load_d = {{(DATA_LEN-8){1'b0}},  lane_data[7:0]};
            3'b101:  load_d = {{(DATA_LEN-16){1'b0}}, lane_data[15:0]};
            3'b110:  load_d = {{(DATA_LEN-32){1'b0}}, lane_data[31:0]};
            default: load_d = '0;
        endcase
        merge_d = (ram_data_i & ~(lane_mask << lane_shamt))
                | ((wdata_q & lane_mask) << lane_shamt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            req_ready_o       <= 1'b1;
            resp_valid_o      <= 1'b0;
            resp_rdata_o      <= '0;
            resp_err_o        <= 1'b0;
            ram_access_mode_o <= MODE_NONE;
            ram_addr_o        <= '0;
            ram_data_o        <= '0;
            we_q              <= 1'b0;
            memwid_q          <= '0;
            off_q             <= '0;
            wdata_q           <= '0;
`ifdef LSU_BADADDR_EN
            addr_q            <= '0;
            resp_badaddr_o    <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_fire) begin
                        we_q        <= req_we_i;
                        memwid_q    <= req_memwid_i;
                        off_q       <= req_addr_i[2:0];
                        wdata_q     <= req_wdata_i;
`ifdef LSU_BADADDR_EN
                        addr_q      <= req_addr_i;
`endif
                        req_ready_o <= 1'b0;
                        if (req_bad) begin
                            state_q <= S_ERR;
                        end else begin
                            ram_addr_o        <= req_addr_i[RAM_SIZE+2:3];
                            ram_access_mode_o <= MODE_READ;
                            state_q           <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    ram_access_mode_o <= MODE_NONE;
                    state_q           <= S_CAP;
                end
                S_CAP: begin
                    if (we_q) begin
                        ram_data_o        <= merge_d;
                        ram_access_mode_o <= MODE_WRITE;
                        state_q           <= S_WR;
                    end else begin
                        resp_rdata_o <= load_d;
                        resp_err_o   <= 1'b0;
                        resp_valid_o <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_WR: begin
                    ram_access_mode_o <= MODE_NONE;
                    resp_rdata_o      <= '0;
                    resp_err_o        <= 1'b0;
                    resp_valid_o      <= 1'b1;
                    state_q           <= S_RESP;
                end
                S_ERR: begin
                    resp_rdata_o   <= '0;
                    resp_err_o     <= 1'b1;
                    resp_valid_o   <= 1'b1;
`ifdef LSU_BADADDR_EN
                    resp_badaddr_o <= addr_q;
`endif
                    state_q        <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o   <= 1'b0;
                        resp_err_o     <= 1'b0;
                        resp_rdata_o   <= '0;
`ifdef LSU_BADADDR_EN
                        resp_badaddr_o <= '0;
`endif
                        req_ready_o    <= 1'b1;
                        state_q        <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a registered-read doubleword RAM model.
// Build with LSU_BADADDR_EN defined to also check resp_badaddr_o.
module tb_lsu_ctrl;

    localparam int unsigned RS = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [63:0]   req_addr = '0;
    logic [63:0]   req_wdata = '0;
    logic [2:0]    req_memwid = '0;
    logic [RS-1:0] ram_addr;
    logic [1:0]    ram_mode;
    logic [2:0]    ram_memwid;
    logic [63:0]   ram_wdata;
    logic [63:0]   ram_rdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [63:0]   resp_rdata;
    logic          resp_err;
`ifdef LSU_BADADDR_EN
    logic [63:0]   resp_badaddr;
`endif

    lsu_ctrl #(.DATA_LEN(64), .RAM_SIZE(RS)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_we_i          (req_we),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .req_memwid_i      (req_memwid),
        .ram_addr_o        (ram_addr),
        .ram_access_mode_o (ram_mode),
        .ram_memwid_o      (ram_memwid),
        .ram_data_o        (ram_wdata),
        .ram_data_i        (ram_rdata),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .resp_rdata_o      (resp_rdata),
`ifdef LSU_BADADDR_EN
        .resp_badaddr_o    (resp_badaddr),
`endif
        .resp_err_o        (resp_err)
    );

    always #5 clk = ~clk;

    logic [63:0]   mem [0:(1<<RS)-1];
    logic          ld_en = 1'b0;
    logic [RS-1:0] ld_idx = '0;
    logic [63:0]   ld_val = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        else if (ram_mode == 2'd2) mem[ram_addr] <= ram_wdata;
        if (ram_mode == 2'd1) ram_rdata <= mem[ram_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [RS-1:0] idx, input logic [63:0] val);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = idx; ld_val = val;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  wid;
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    // Issues one request, measures latency and RAM traffic, checks the response, completes the handshake.
    task automatic txn(input string tag, input vec_t v);
        int lat, nrd, nwr, guard;
        guard = 0;
        while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        chk({tag, ".ready_before"}, {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
        req_wdata = v.wdata; req_memwid = v.wid; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0;
        while (!resp_valid && lat < 20) begin
            if (ram_mode == 2'd1) nrd++;
            if (ram_mode == 2'd2) nwr++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(v.lat));
        chk({tag, ".reads"},  64'(nrd), v.err ? 64'd0 : 64'd1);
        chk({tag, ".writes"}, 64'(nwr), (v.err || !v.we) ? 64'd0 : 64'd1);
        chk({tag, ".rdata"}, resp_rdata, v.rdata);
        chk({tag, ".err"}, {63'd0, resp_err}, {63'd0, v.err});
`ifdef LSU_BADADDR_EN
        chk({tag, ".badaddr"}, resp_badaddr, v.err ? v.addr : 64'd0);
`endif
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, ".valid_drop"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, ".ready_after"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        vec_t   v;
        logic [63:0] held;
        int     nwr;

        vecs[0]  = '{1'b0, 64'h0F,   64'h0, 3'b100, 64'h0000_0000_0000_0088, 1'b0, 2};
        vecs[1]  = '{1'b0, 64'h0F,   64'h0, 3'b000, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 2};
        vecs[2]  = '{1'b1, 64'h0A,   64'hBEEF, 3'b001, 64'h0, 1'b0, 3};
        vecs[3]  = '{1'b0, 64'h08,   64'h0, 3'b011, 64'h8877_6655_BEEF_2211, 1'b0, 2};
        vecs[4]  = '{1'b0, 64'h06,   64'h0, 3'b010, 64'h0, 1'b1, 1};
        vecs[5]  = '{1'b0, 64'h8000, 64'h0, 3'b011, 64'h0, 1'b1, 1};
        vecs[6]  = '{1'b0, 64'h08,   64'h0, 3'b111, 64'h0, 1'b1, 1};
        vecs[7]  = '{1'b0, 64'h0A,   64'h0, 3'b001, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 2};
        vecs[8]  = '{1'b0, 64'h0A,   64'h0, 3'b101, 64'h0000_0000_0000_BEEF, 1'b0, 2};
        vecs[9]  = '{1'b0, 64'h0C,   64'h0, 3'b010, 64'hFFFF_FFFF_8877_6655, 1'b0, 2};
        vecs[10] = '{1'b0, 64'h0C,   64'h0, 3'b110, 64'h0000_0000_8877_6655, 1'b0, 2};
        vecs[11] = '{1'b1, 64'h08,   64'h5A, 3'b100, 64'h0, 1'b1, 1};
        vecs[12] = '{1'b1, 64'h10,   64'hDEAD_BEEF_1234_5678, 3'b010, 64'h0, 1'b0, 3};
        vecs[13] = '{1'b0, 64'h10,   64'h0, 3'b011, 64'hAAAA_AAAA_1234_5678, 1'b0, 2};
        vecs[14] = '{1'b1, 64'h18,   64'h0123_4567_89AB_CDEF, 3'b011, 64'h0, 1'b0, 3};
        vecs[15] = '{1'b0, 64'h1F,   64'h0, 3'b000, 64'h0000_0000_0000_0001, 1'b0, 2};
        vecs[16] = '{1'b0, 64'h18,   64'h0, 3'b000, 64'hFFFF_FFFF_FFFF_FFEF, 1'b0, 2};
        vecs[17] = '{1'b0, 64'h7FFC, 64'h0, 3'b010, 64'h0000_0000_1122_3344, 1'b0, 2};
        vecs[18] = '{1'b0, 64'h0B,   64'h0, 3'b001, 64'h0, 1'b1, 1};

        preload(12'd1,   64'h8877_6655_4433_2211);
        preload(12'd2,   64'hAAAA_AAAA_AAAA_AAAA);
        preload(12'd3,   64'h0);
        preload(12'd4,   64'h5555_5555_5555_5555);
        preload(12'd4095, 64'h1122_3344_5566_7788);

        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("reset.ready", {63'd0, req_ready}, 64'd1);
            chk("reset.valid", {63'd0, resp_valid}, 64'd0);
            chk("reset.mode",  {62'd0, ram_mode}, 64'd0);
        end
        chk("reset.rdata",  resp_rdata, 64'd0);
        chk("reset.err",    {63'd0, resp_err}, 64'd0);
        chk("reset.raddr",  {52'd0, ram_addr}, 64'd0);
        chk("reset.rwdata", ram_wdata, 64'd0);
        chk("reset.memwid", {61'd0, ram_memwid}, 64'd3);

        for (int i = 0; i < NV; i++) txn($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: response held four cycles while another request waits.
        v = '{1'b0, 64'h08, 64'h0, 3'b011, 64'h8877_6655_BEEF_2211, 1'b0, 2};
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = v.addr; req_memwid = v.wid;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !resp_valid; i++) begin @(posedge clk); #1; end
        chk("bp.valid", {63'd0, resp_valid}, 64'd1);
        held = resp_rdata;
        chk("bp.rdata", held, v.rdata);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 64'h10;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("bp.hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp.hold_rdata", resp_rdata, v.rdata);
            chk("bp.hold_ready", {63'd0, req_ready}, 64'd0);
            chk("bp.hold_mode",  {62'd0, ram_mode}, 64'd0);
        end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp.release", {63'd0, resp_valid}, 64'd0);
        repeat (2) @(posedge clk); #1;
        chk("bp.no_accept", {63'd0, req_ready}, 64'd1);

        // Reset during CAP of a store: no write and RAM[4] unchanged.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h20;
        req_wdata = 64'h00FF; req_memwid = 3'b000;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        chk("abort.rd", {62'd0, ram_mode}, 64'd1);
        @(posedge clk); #1;
        nwr = 0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        if (ram_mode == 2'd2) nwr++;
        chk("abort.mode",  {62'd0, ram_mode}, 64'd0);
        chk("abort.ready", {63'd0, req_ready}, 64'd1);
        chk("abort.valid", {63'd0, resp_valid}, 64'd0);
        chk("abort.wdata", ram_wdata, 64'd0);
        chk("abort.raddr", {52'd0, ram_addr}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ram_mode == 2'd2) nwr++;
        end
        chk("abort.writes", 64'(nwr), 64'd0);
        chk("abort.ram", mem[4], 64'h5555_5555_5555_5555);
        txn("abort.reload", '{1'b0, 64'h20, 64'h0, 3'b011, 64'h5555_5555_5555_5555, 1'b0, 2});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
